imem_responder: RTL and testbench

- Memory-side responder for the tagged split-transaction bus used by the instruction and data caches.
- Accepts one BUS_LOAD or BUS_STORE command per cycle and answers with a nonzero 4-bit response tag in the same cycle. Returns 64-bit load data tagged with that same tag exactly MEM_LATENCY cycles later.
- Serves as the synthesizable memory model behind the cache front ends and as the reference responder for cache verification.

---
 rtl/imem_responder.sv | 88 ++++++++
 tb/tb_imem_responder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Memory-side responder for the tagged split-transaction bus: issues rotating
// nonzero tags on accept and returns load data MEM_LATENCY cycles later.
`ifndef XLEN
`define XLEN 32
`endif

module imem_responder #(
    parameter int unsigned MEM_LATENCY     = 4,
    parameter int unsigned MEM_DEPTH_WORDS = 8192,
    parameter int unsigned XLEN            = `XLEN
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [1:0]      proc2mem_command,
    input  logic [XLEN-1:0] proc2mem_addr,
    input  logic [63:0]     proc2mem_data,
    output logic [3:0]      mem2proc_response,
    output logic [63:0]     mem2proc_data,
    output logic [3:0]      mem2proc_tag
);

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } bus_cmd_e;

    localparam int unsigned IDX_W = XLEN - 3;
    localparam int unsigned AW    = $clog2(MEM_DEPTH_WORDS);

    logic [63:0]      mem [MEM_DEPTH_WORDS];
    logic [3:0]       pipe_tag  [MEM_LATENCY];
    logic [63:0]      pipe_data [MEM_LATENCY];
    logic [3:0]       next_tag;

    logic [IDX_W-1:0] word_idx;
    logic [AW-1:0]    mem_addr;
    logic             in_range;
    logic             is_load;
    logic             is_store;
    logic             tag_busy;
    logic             accept;
    logic             unused_addr_bits;

    assign word_idx         = proc2mem_addr[XLEN-1:3];
    assign mem_addr         = word_idx[AW-1:0];
    assign in_range         = ({1'b0, word_idx} < (IDX_W+1)'(MEM_DEPTH_WORDS));
    assign unused_addr_bits = ^proc2mem_addr[2:0];

    // Tag 0 never enters the pipe as a valid entry, so a match on the nonzero
    // next_tag is exactly "tag still in flight".
    always_comb begin
        is_load  = (proc2mem_command == BUS_LOAD);
        is_store = (proc2mem_command == BUS_STORE);
        tag_busy = 1'b0;
        for (int unsigned i = 0; i < MEM_LATENCY; i++) begin
            if (pipe_tag[i] == next_tag) tag_busy = 1'b1;
        end
        accept            = reset && (is_load || is_store) && in_range && !tag_busy;
        mem2proc_response = accept ? next_tag : '0;
    end

    always_ff @(posedge clock) begin
        if (accept && is_store) mem[mem_addr] <= proc2mem_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            next_tag <= 4'd1;
            for (int unsigned i = 0; i < MEM_LATENCY; i++) begin
                pipe_tag[i]  <= '0;
                pipe_data[i] <= '0;
            end
        end else begin
            if (accept) next_tag <= (next_tag == 4'd15) ? 4'd1 : next_tag + 4'd1;
            pipe_tag[0]  <= (accept && is_load) ? next_tag : '0;
            pipe_data[0] <= (accept && is_load) ? mem[mem_addr] : '0;
            for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
                pipe_tag[i]  <= pipe_tag[i-1];
                pipe_data[i] <= pipe_data[i-1];
            end
        end
    end

    assign mem2proc_tag  = pipe_tag[MEM_LATENCY-1];
    assign mem2proc_data = pipe_data[MEM_LATENCY-1];

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: queue/array reference model checked every
// cycle, plus literal expectations along the directed sequence.
module tb_imem_responder;

    localparam int LAT   = 4;
    localparam int DEPTH = 8192;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  proc2mem_command = 2'd0;
    logic [31:0] proc2mem_addr = '0;
    logic [63:0] proc2mem_data = '0;
    logic [3:0]  mem2proc_response;
    logic [63:0] mem2proc_data;
    logic [3:0]  mem2proc_tag;

    imem_responder #(.MEM_LATENCY(LAT), .MEM_DEPTH_WORDS(DEPTH), .XLEN(32)) dut (
        .clock(clock), .reset(reset),
        .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
        .proc2mem_data(proc2mem_data), .mem2proc_response(mem2proc_response),
        .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: sparse word store, pending returns keyed by due cycle.
    typedef struct {
        int          due;
        logic [3:0]  tag;
        logic [63:0] data;
        bit          known;
    } ret_t;

    logic [63:0] model_mem [int];
    ret_t        pend [$];
    logic [3:0]  mtag = 4'd1;
    int          cyc = 0;
    bit          acc = 0;
    bit          acc_load = 0;
    int          acc_idx = 0;
    logic [63:0] acc_wdata = '0;
    logic [63:0] acc_rdata = '0;
    bit          acc_known = 0;

    always @(negedge clock) begin
        if (!reset) begin
            chk("rst_response", 64'(mem2proc_response), 64'd0);
            chk("rst_tag", 64'(mem2proc_tag), 64'd0);
            chk("rst_data", mem2proc_data, 64'd0);
            pend.delete();
            mtag = 4'd1;
            acc  = 0;
        end else begin
            int   idx;
            bit   cmd_ok;
            bit   busy;
            bit   found;
            ret_t r;
            idx    = int'(proc2mem_addr >> 3);
            cmd_ok = (proc2mem_command == 2'd1) || (proc2mem_command == 2'd2);
            busy   = 0;
            foreach (pend[k]) if (pend[k].tag == mtag) busy = 1;
            acc = cmd_ok && (idx < DEPTH) && !busy;
            chk("response", 64'(mem2proc_response), acc ? 64'(mtag) : 64'd0);
            acc_load  = (proc2mem_command == 2'd1);
            acc_idx   = idx;
            acc_wdata = proc2mem_data;
            acc_known = model_mem.exists(idx);
            acc_rdata = acc_known ? model_mem[idx] : 64'd0;

            found = 0;
            foreach (pend[k]) if (pend[k].due == cyc) begin found = 1; r = pend[k]; end
            if (found) begin
                chk("ret_tag", 64'(mem2proc_tag), 64'(r.tag));
                if (r.known) chk("ret_data", mem2proc_data, r.data);
            end else begin
                chk("idle_tag", 64'(mem2proc_tag), 64'd0);
                chk("idle_data", mem2proc_data, 64'd0);
            end
        end
    end

    always @(posedge clock) begin
        if (reset) begin
            if (acc) begin
                if (acc_load) pend.push_back('{cyc + LAT, mtag, acc_rdata, acc_known});
                else          model_mem[acc_idx] = acc_wdata;
                mtag = (mtag == 4'd15) ? 4'd1 : mtag + 4'd1;
            end
            acc = 0;
            cyc++;
            while (pend.size() > 0 && pend[0].due < cyc) void'(pend.pop_front());
        end
    end

    // Drive one command for one cycle and optionally pin the response literally.
    task automatic issue(input logic [1:0] c, input logic [31:0] a, input logic [63:0] d,
                         input int er);
        @(posedge clock);
        #1;
        proc2mem_command = c;
        proc2mem_addr    = a;
        proc2mem_data    = d;
        @(negedge clock);
        if (er >= 0) chk("lit_response", 64'(mem2proc_response), 64'(er));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(2'd0, 32'h0, 64'h0, 0);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        proc2mem_command = 2'd0;
        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    function automatic logic [63:0] pat(input int i);
        return 64'h0BAD_F00D_0000_0000 + 64'(i) * 64'h0101;
    endfunction

    initial begin
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;

        // Preload through the bus; stores survive the resets that follow.
        issue(2'd2, 32'h100, 64'h0123_4567_89AB_CDEF, -1);
        for (int i = 0; i < 16; i++) issue(2'd2, 32'(i * 8), pat(i), -1);
        issue(2'd2, 32'h300, 64'h3333_3333_3333_3333, -1);

        // Single load latency.
        do_reset();
        issue(2'd1, 32'h100, 64'h0, 1);
        idle(3);
        chk("lit_tag_before", 64'(mem2proc_tag), 64'd0);
        idle(1);
        chk("lit_tag_ret", 64'(mem2proc_tag), 64'd1);
        chk("lit_data_ret", mem2proc_data, 64'h0123_4567_89AB_CDEF);
        idle(1);
        chk("lit_tag_after", 64'(mem2proc_tag), 64'd0);

        // Sixteen back-to-back loads with tag wrap.
        do_reset();
        for (int i = 0; i < 16; i++) issue(2'd1, 32'(i * 8), 64'h0, (i % 15) + 1);
        idle(4);
        chk("lit_wrap_tag", 64'(mem2proc_tag), 64'd1);
        chk("lit_wrap_data", mem2proc_data, 64'h0BAD_F00D_0000_0F0F);
        idle(2);

        // Store then load of the same word via a different byte offset.
        do_reset();
        issue(2'd2, 32'h200, 64'hDEAD_BEEF_0000_0001, 1);
        issue(2'd1, 32'h204, 64'h0, 2);
        idle(3);
        chk("lit_no_store_ret", 64'(mem2proc_tag), 64'd0);
        idle(1);
        chk("lit_st_ld_tag", 64'(mem2proc_tag), 64'd2);
        chk("lit_st_ld_data", mem2proc_data, 64'hDEAD_BEEF_0000_0001);

        // Load then store: the load returns the pre-store value.
        do_reset();
        issue(2'd1, 32'h300, 64'h0, 1);
        issue(2'd2, 32'h300, 64'hFF, 2);
        idle(3);
        chk("lit_ld_st_tag", 64'(mem2proc_tag), 64'd1);
        chk("lit_ld_st_data", mem2proc_data, 64'h3333_3333_3333_3333);
        issue(2'd1, 32'h301, 64'h0, 3);
        idle(LAT);
        chk("lit_new_val", mem2proc_data, 64'hFF);

        // Out-of-range address and command 3 are rejected without using a tag.
        do_reset();
        issue(2'd1, 32'(DEPTH * 8), 64'h0, 0);
        issue(2'd1, 32'(DEPTH * 8 + 5), 64'h0, 0);
        issue(2'd3, 32'h100, 64'h0, 0);
        issue(2'd1, 32'(DEPTH * 8 - 8), 64'h0, 1);
        issue(2'd1, 32'h100, 64'h0, 2);
        idle(LAT + 1);

        // Mid-operation reset discards in-flight loads.
        do_reset();
        issue(2'd1, 32'h0, 64'h0, 1);
        issue(2'd1, 32'h8, 64'h0, 2);
        issue(2'd1, 32'h10, 64'h0, 3);
        @(posedge clock);
        #1;
        proc2mem_command = 2'd0;
        reset = 1'b0;
        #3;
        chk("lit_async_tag", 64'(mem2proc_tag), 64'd0);
        #2;
        reset = 1'b1;
        for (int i = 0; i < LAT + 2; i++) begin
            issue(2'd0, 32'h0, 64'h0, 0);
            chk("lit_discard_tag", 64'(mem2proc_tag), 64'd0);
        end
        issue(2'd1, 32'h8, 64'h0, 1);
        idle(LAT + 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
